// File: rtl/regfile_sb.sv
// Two-bank (integer/float) register file with NRD registered read ports, NWR
// prioritised write ports and a per-register busy scoreboard. Optional macro:
// REGFILE_SB_BYPASS_EN forwards same-cycle writes and post-edge busy to reads.
module regfile_sb #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  parameter  int NWR  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRD-1:0]      rd_bank,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR-1:0]      wr_bank,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NWR-1:0]      wr_clr,
  input  logic                sb_set,
  input  logic                sb_bank,
  input  logic [AW-1:0]       sb_addr,
  output logic                any_busy
);

  logic [XLEN-1:0] mem [2][NREG];
  logic [NREG-1:0] busy [2];
  logic [NREG-1:0] busy_nxt [2];
  logic [NREG-1:0] clr_vec [2];
  logic [NREG-1:0] set_vec [2];
  logic [NWR-1:0]  wr_ok;
  logic [NRD*XLEN-1:0] rd_data_d;
  logic [NRD-1:0]      rd_busy_d;

  // Integer register 0 is never written and never marked busy.
  always_comb begin
    wr_ok = '0;
    for (int w = 0; w < NWR; w++)
      wr_ok[w] = we[w] & ~(~wr_bank[w] & (wr_addr[w*AW +: AW] == '0));
  end

  // Ascending port order lets the highest-index port decide the clear; set wins last.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      clr_vec[b] = '0;
      set_vec[b] = '0;
    end
    for (int w = 0; w < NWR; w++)
      if (wr_ok[w])
        clr_vec[wr_bank[w]][wr_addr[w*AW +: AW]] = wr_clr[w];
    if (sb_set && !(!sb_bank && sb_addr == '0))
      set_vec[sb_bank][sb_addr] = 1'b1;
    for (int b = 0; b < 2; b++)
      busy_nxt[b] = (busy[b] & ~clr_vec[b]) | set_vec[b];
  end

  always_ff @(posedge clk) begin
    if (rstn)
      for (int w = 0; w < NWR; w++)
        if (wr_ok[w])
          mem[wr_bank[w]][wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy[0]  <= '0;
      busy[1]  <= '0;
      any_busy <= 1'b0;
    end else begin
      busy[0]  <= busy_nxt[0];
      busy[1]  <= busy_nxt[1];
      any_busy <= (|busy_nxt[0]) | (|busy_nxt[1]);
    end
  end

`ifdef REGFILE_SB_BYPASS_EN
  logic [NRD-1:0]  fwd_hit;
  logic [XLEN-1:0] fwd_data [NRD];

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      fwd_hit[i]  = 1'b0;
      fwd_data[i] = '0;
      for (int w = 0; w < NWR; w++)
        if (wr_ok[w] && wr_bank[w] == rd_bank[i] &&
            wr_addr[w*AW +: AW] == rd_addr[i*AW +: AW]) begin
          fwd_hit[i]  = 1'b1;
          fwd_data[i] = wr_data[w*XLEN +: XLEN];
        end
    end
  end
`endif

  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_bank[i] || rd_addr[i*AW +: AW] != '0) begin
`ifdef REGFILE_SB_BYPASS_EN
        rd_data_d[i*XLEN +: XLEN] = fwd_hit[i] ? fwd_data[i]
                                               : mem[rd_bank[i]][rd_addr[i*AW +: AW]];
        rd_busy_d[i] = busy_nxt[rd_bank[i]][rd_addr[i*AW +: AW]];
`else
        rd_data_d[i*XLEN +: XLEN] = mem[rd_bank[i]][rd_addr[i*AW +: AW]];
        rd_busy_d[i] = busy[rd_bank[i]][rd_addr[i*AW +: AW]];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      rd_data <= rd_data_d;
      rd_busy <= rd_busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected read/busy results,
// a monitor pops and compares them one cycle after the read is presented.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = $clog2(NREG);

  logic                clk = 1'b0;
  logic                rstn;
  logic [NRD-1:0]      rd_bank;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      we;
  logic [NWR-1:0]      wr_bank;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NWR-1:0]      wr_clr;
  logic                sb_set;
  logic                sb_bank;
  logic [AW-1:0]       sb_addr;
  logic                any_busy;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rstn(rstn),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .sb_set(sb_set), .sb_bank(sb_bank), .sb_addr(sb_addr), .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;   // 0 rd_data, 1 rd_busy, 2 any_busy
    int          port;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  // Monitor: results of inputs driven in cycle N are due after posedge N+1.
  always @(posedge clk) begin
    item_t it;
    logic [31:0] act;
    #1;
    cyc++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      it = q.pop_front();
      case (it.kind)
        0:       act = rd_data[it.port*XLEN +: XLEN];
        1:       act = {31'b0, rd_busy[it.port]};
        default: act = {31'b0, any_busy};
      endcase
      checks++;
      if (it.cyc != cyc || act !== it.exp) begin
        errors++;
        $display("FAIL %s: port %0d got %h expected %h (due cyc %0d, at cyc %0d)",
                 it.name, it.port, act, it.exp, it.cyc, cyc);
      end
    end
  end

  task automatic push(int kind, int port, logic [31:0] exp, string name);
    item_t it;
    it.cyc = cyc + 1; it.kind = kind; it.port = port; it.exp = exp; it.name = name;
    q.push_back(it);
  endtask

  task automatic exp_data(int p, logic [31:0] d, string n); push(0, p, d, n); endtask
  task automatic exp_busy(int p, logic b, string n); push(1, p, {31'b0, b}, n); endtask
  task automatic exp_any(logic a, string n); push(2, 0, {31'b0, a}, n); endtask

  task automatic set_rd(int p, logic bank, int addr);
    rd_bank[p] = bank;
    rd_addr[p*AW +: AW] = addr[AW-1:0];
  endtask

  task automatic set_wr(int p, logic bank, int addr, logic [31:0] d, logic clr);
    we[p] = 1'b1;
    wr_bank[p] = bank;
    wr_addr[p*AW +: AW] = addr[AW-1:0];
    wr_data[p*XLEN +: XLEN] = d;
    wr_clr[p] = clr;
  endtask

  task automatic set_sb(logic bank, int addr);
    sb_set = 1'b1; sb_bank = bank; sb_addr = addr[AW-1:0];
  endtask

  // Advance to the next negedge and drop all single-cycle strobes.
  task automatic tick();
    @(negedge clk);
    we = '0; wr_clr = '0; sb_set = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; rd_bank = '0; rd_addr = '0; we = '0; wr_bank = '0; wr_addr = '0;
    wr_data = '0; wr_clr = '0; sb_set = 1'b0; sb_bank = 1'b0; sb_addr = '0;

    // Reset state
    tick();
    set_rd(0, 1'b0, 5); set_rd(1, 1'b1, 5);
    exp_data(0, 32'h0, "rst_data0"); exp_busy(0, 1'b0, "rst_busy0");
    exp_data(1, 32'h0, "rst_data1"); exp_any(1'b0, "rst_any");
    tick();
    rstn = 1'b1;

    // Basic write then read
    set_wr(0, 1'b0, 5, 32'h1234_5678, 1'b0);
    tick();
    set_rd(0, 1'b0, 5);
    exp_data(0, 32'h1234_5678, "int_r5"); exp_busy(0, 1'b0, "int_r5_busy");
    tick();

    // Integer r0 is hardwired; float r0 is ordinary
    set_wr(0, 1'b0, 0, 32'hFFFF_FFFF, 1'b0); set_sb(1'b0, 0);
    set_wr(1, 1'b1, 0, 32'hDEAD_BEEF, 1'b0);
    exp_any(1'b0, "int_r0_sb_any");
    tick();
    set_rd(0, 1'b0, 0); set_rd(1, 1'b0, 0);
    exp_data(0, 32'h0, "int_r0_p0"); exp_data(1, 32'h0, "int_r0_p1");
    exp_busy(0, 1'b0, "int_r0_busy0"); exp_busy(1, 1'b0, "int_r0_busy1");
    tick();
    set_rd(1, 1'b1, 0);
    exp_data(1, 32'hDEAD_BEEF, "fp_r0");
    tick();

    // Write-port priority
    set_wr(0, 1'b1, 3, 32'hAAAA_AAAA, 1'b0); set_wr(1, 1'b1, 3, 32'h5555_5555, 1'b0);
    tick();
    set_rd(0, 1'b1, 3); set_rd(1, 1'b1, 3);
    exp_data(0, 32'h5555_5555, "fp_r3_prio_p0"); exp_data(1, 32'h5555_5555, "fp_r3_prio_p1");
    tick();

    // Scoreboard set / set+clear / clear
    set_sb(1'b0, 7);
    exp_any(1'b1, "sb_set_any");
    tick();
    set_sb(1'b0, 7); set_wr(0, 1'b0, 7, 32'h0000_0077, 1'b1);
    set_rd(0, 1'b0, 7);
    exp_busy(0, 1'b1, "set_clr_busy_rd"); exp_any(1'b1, "set_clr_any");
    tick();
    set_wr(0, 1'b0, 7, 32'h0000_0078, 1'b1);
    set_rd(0, 1'b0, 7);
`ifdef REGFILE_SB_BYPASS_EN
    exp_busy(0, 1'b0, "clr_busy_same"); exp_data(0, 32'h0000_0078, "clr_data_same");
`else
    exp_busy(0, 1'b1, "clr_busy_same"); exp_data(0, 32'h0000_0077, "clr_data_same");
`endif
    exp_any(1'b0, "clr_any");
    tick();
    set_rd(0, 1'b0, 7);
    exp_busy(0, 1'b0, "clr_busy_after"); exp_data(0, 32'h0000_0078, "r7_data_after");
    tick();

    // Same-cycle read and write of int r9
    set_wr(0, 1'b0, 9, 32'h0, 1'b0);
    tick();
    set_wr(1, 1'b0, 9, 32'hCAFE_0001, 1'b0);
    set_rd(1, 1'b0, 9);
`ifdef REGFILE_SB_BYPASS_EN
    exp_data(1, 32'hCAFE_0001, "r9_same_cycle");
`else
    exp_data(1, 32'h0, "r9_same_cycle");
`endif
    tick();
    set_rd(1, 1'b0, 9);
    exp_data(1, 32'hCAFE_0001, "r9_after");
    tick();

    // Reset mid-operation drops busy bits and blocks writes/sets
    set_sb(1'b0, 2);
    tick();
    set_sb(1'b1, 2);
    exp_any(1'b1, "pre_rst_any");
    tick();
    rstn = 1'b0;
    set_wr(0, 1'b0, 5, 32'h0000_0BAD, 1'b0); set_sb(1'b0, 4);
    set_rd(0, 1'b0, 2); set_rd(1, 1'b1, 2);
    exp_data(0, 32'h0, "rst_mid_data0"); exp_data(1, 32'h0, "rst_mid_data1");
    exp_busy(0, 1'b0, "rst_mid_busy0"); exp_busy(1, 1'b0, "rst_mid_busy1");
    exp_any(1'b0, "rst_mid_any");
    tick();
    rstn = 1'b1;
    set_wr(0, 1'b0, 2, 32'h2222_2222, 1'b0);
    set_rd(1, 1'b1, 2);
    exp_busy(1, 1'b0, "post_rst_fp_r2_busy"); exp_any(1'b0, "post_rst_any");
    tick();
    set_rd(0, 1'b0, 2); set_rd(1, 1'b0, 5);
    exp_data(0, 32'h2222_2222, "post_rst_int_r2"); exp_busy(0, 1'b0, "post_rst_int_r2_busy");
    exp_data(1, 32'h1234_5678, "r5_unchanged_by_rst_write");
    exp_any(1'b0, "rst_sb_ignored_any");
    tick();
    tick();
    tick();

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected results never compared, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's integer/float register storage.
- Two register banks: bank 0 is integer, bank 1 is float. Integer register 0 is hardwired to zero.
- Configurable numbers of registered read ports and write ports, optional write-to-read forwarding, and a per-register busy scoreboard.
- Sits between decode/issue (reads, scoreboard set) and the writeback stage (writes, scoreboard clear). The PC stays in the core.

Parameters:
- XLEN, 32: data width of every register.
- NREG, 32: registers per bank. Power of two, at least 2. Localparam AW = $clog2(NREG).
- NRD, 2: number of read ports, at least 1.
- NWR, 2: number of write ports, at least 1. Higher index has higher priority.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  synchronous reset, active-low.
- rd_bank  in  NRD  per-port bank select: 0 = integer, 1 = float.
- rd_addr  in  NRD*AW  per-port register index; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  per-port registered read data.
- rd_busy  out  NRD  per-port registered scoreboard bit for the addressed register.
- we  in  NWR  per-port write enable.
- wr_bank  in  NWR  per-port write bank.
- wr_addr  in  NWR*AW  per-port write index.
- wr_data  in  NWR*XLEN  per-port write data.
- wr_clr  in  NWR  when set together with we, the write also clears the target's busy bit.
- sb_set  in  1  mark register sb_bank/sb_addr busy (instruction issued).
- sb_bank  in  1  bank for sb_set.
- sb_addr  in  AW  index for sb_set.
- any_busy  out  1  registered OR of all busy bits, both banks.

Behaviour:
- Reset (rstn low at posedge): rd_data = 0, rd_busy = 0, any_busy = 0, all busy bits cleared.
  - Writes and sb_set are ignored while reset is asserted.
  - Register contents are not reset. The bench must write a register before checking its value.
  - Reset asserted mid-operation drops any pending busy bits in the same cycle.
- Reads:
  - One-cycle latency: rd_data/rd_busy sampled at posedge N reflect rd_bank/rd_addr presented in cycle N.
  - Reads are performed every cycle; there is no read enable.
- Integer register 0:
  - Reads of integer register 0 always return 0 and busy 0.
  - Writes and sb_set targeting it are discarded.
  - Float register 0 is an ordinary register.
- Writes:
  - A write takes effect at posedge and is visible to a read issued in the following cycle.
  - If several write ports target the same bank/index in one cycle, the highest-index port wins, for both data and clear.
- Scoreboard, one bit per register per bank:
  - sb_set sets the bit.
  - we & wr_clr clears it.
  - If set and clear hit the same register in the same cycle, set wins (a new producer was issued).
  - Setting an already-busy bit leaves it busy; clearing an idle bit leaves it idle.
- any_busy is registered and reflects the busy state after the current edge's updates.
- Ports are independent. All NRD reads may address the same register.
- Out-of-range indices cannot occur because NREG is a power of two.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined:
  - A read issued in the same cycle as a matching write (same bank/index, not integer register 0) returns that cycle's winning wr_data.
  - rd_busy returns the post-edge busy value, including same-cycle set and clear.
- Undefined:
  - Same-cycle matching reads return the pre-write contents.
  - rd_busy returns the pre-edge bit.
  - The issue stage must then insert one stall cycle.

Test Plan:
- Reset, then write int r5 = 0x1234_5678 via port 0; read int r5 the next cycle → rd_data = 0x12345678 one cycle after the read is presented.
- Write int r0 = 0xFFFF_FFFF, then read int r0 on all ports → 0 and busy 0. Write float r0 = 0xDEAD_BEEF, then read it → 0xDEADBEEF.
- Same cycle: port0 writes float r3 = 0xAAAA_AAAA, port1 writes float r3 = 0x5555_5555. Then read float r3 → 0x55555555.
- sb_set on int r7 → rd_busy = 1 and any_busy = 1.
  - In one cycle, assert sb_set on r7 together with a clearing write to r7 → r7 remains busy.
  - Next cycle, a clearing write only → busy 0, any_busy 0.
- Same-cycle read and write of int r9 = 0xCAFE_0001 (old value 0x0):
  - With REGFILE_SB_BYPASS_EN → rd_data = 0xCAFE0001.
  - Without it → rd_data = 0x0.
- Set busy on int r2 and float r2, then assert rstn low for one cycle → all busy bits 0, any_busy 0, rd_data 0. After reset, a write to int r2 is accepted.
